// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared types for the FIFO drain arbiter
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

endpackage

// File: rtl/fifo_drain_arbiter_rr_pick.sv
// rtl/fifo_drain_arbiter_rr_pick.sv - combinational round-robin picker
module rr_pick #(
  parameter int N_PORTS  = 4,
  parameter int ID_WIDTH = $clog2(N_PORTS)
) (
  input  logic [N_PORTS-1:0]  req,
  input  logic [ID_WIDTH-1:0] last,
  output logic                any,
  output logic [ID_WIDTH-1:0] idx
);

  logic [ID_WIDTH-1:0] pos;

  always_comb begin
    any = 1'b0;
    idx = '0;
    pos = '0;
    // Walk last+1 .. last+N so the previous owner is considered last.
    for (int k = 1; k <= N_PORTS; k++) begin
      pos = ID_WIDTH'((int'(last) + k) % N_PORTS);
      if (!any && req[pos]) begin
        any = 1'b1;
        idx = pos;
      end
    end
  end

endmodule

// File: rtl/fifo_drain_arbiter.sv
// rtl/fifo_drain_arbiter.sv - round-robin burst drain of N FIFOs onto one stream
module fifo_drain_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N_PORTS    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4,
  parameter int ID_WIDTH   = $clog2(N_PORTS)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_PORTS-1:0]            port_en,
  input  logic [N_PORTS-1:0]            fifo_empty,
  input  logic [N_PORTS*DATA_WIDTH-1:0] fifo_data,
  output logic [N_PORTS-1:0]            fifo_r_en,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [ID_WIDTH-1:0]           out_src,
  output logic                          out_last,
  output logic                          busy
);

  localparam int                  CNT_W     = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0]    LAST_CNT  = CNT_W'(MAX_BURST - 1);
  localparam logic [ID_WIDTH-1:0] INIT_LAST = ID_WIDTH'(N_PORTS - 1);
  localparam logic [N_PORTS-1:0]  ONE_HOT0  = N_PORTS'(1);

  arb_state_t            state;
  logic [ID_WIDTH-1:0]   grant;
  logic [ID_WIDTH-1:0]   last_grant;
  logic [ID_WIDTH-1:0]   pick_idx;
  logic [CNT_W-1:0]      burst_cnt;
  logic                  pick_any;
  logic                  in_burst;
  logic                  pop;
  logic [N_PORTS-1:0]    elig;
  logic [DATA_WIDTH-1:0] words [N_PORTS];

  for (genvar g = 0; g < N_PORTS; g++) begin : g_words
    assign words[g] = fifo_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  assign elig = port_en & ~fifo_empty;

  rr_pick #(
    .N_PORTS  (N_PORTS),
    .ID_WIDTH (ID_WIDTH)
  ) u_pick (
    .req  (elig),
    .last (last_grant),
    .any  (pick_any),
    .idx  (pick_idx)
  );

  // Empty is sampled live, so a word is never offered from a drained FIFO.
  assign in_burst  = (state == BURST);
  assign out_valid = in_burst & port_en[grant] & ~fifo_empty[grant];
  assign pop       = out_valid & out_ready;
  assign fifo_r_en = pop ? (ONE_HOT0 << grant) : '0;
  assign out_last  = out_valid & (burst_cnt == LAST_CNT);
  assign out_src   = in_burst ? grant : '0;
  assign out_data  = out_valid ? words[grant] : '0;
  assign busy      = in_burst;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= INIT_LAST;
      burst_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            grant     <= pick_idx;
            burst_cnt <= '0;
            state     <= BURST;
          end
        end
        BURST: begin
          if (!out_valid) begin
            last_grant <= grant;
            state      <= IDLE;
          end else if (pop) begin
            burst_cnt <= burst_cnt + CNT_W'(1);
            if (burst_cnt == LAST_CNT) begin
              last_grant <= grant;
              state      <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_drain_arbiter.sv
// tb/tb_fifo_drain_arbiter.sv - self-checking bench for fifo_drain_arbiter
module tb_fifo_drain_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 4;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    port_en;
  logic [N-1:0]    fifo_empty;
  logic [N*DW-1:0] fifo_data;
  logic [N-1:0]    fifo_r_en;
  logic [DW-1:0]   out_data;
  logic            out_valid;
  logic            out_ready;
  logic [IW-1:0]   out_src;
  logic            out_last;
  logic            busy;

  fifo_drain_arbiter #(
    .N_PORTS    (N),
    .DATA_WIDTH (DW),
    .MAX_BURST  (MB),
    .ID_WIDTH   (IW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .port_en    (port_en),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_r_en  (fifo_r_en),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_src    (out_src),
    .out_last   (out_last),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef logic [DW-1:0] wq_t[$];
  wq_t q [N];

  // Model: who owns the stream (-1 = nobody), words taken this grant, previous owner.
  int m_owner;
  int m_taken;
  int m_prev;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int log_src[$];
  int log_cyc[$];
  int log_data[$];
  int log_last[$];
  int hold_data[$];
  logic [N-1:0] pend;

  task automatic chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  task automatic chk_list(string name, int got[$], int exp[$]);
    chk({name, "_len"}, got.size(), exp.size());
    for (int k = 0; k < exp.size() && k < got.size(); k++) chk(name, got[k], exp[k]);
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      fifo_empty[i] = (q[i].size() == 0);
      fifo_data[i*DW +: DW] = (q[i].size() == 0) ? (8'hE0 | 8'(i)) : q[i][0];
    end
  endtask

  task automatic load(int port, int n);
    for (int k = 0; k < n; k++) q[port].push_back(8'(port * 64 + k));
    drive();
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_taken = 0;
    m_prev  = N - 1;
  endtask

  task automatic clear_logs();
    log_src.delete();
    log_cyc.delete();
    log_data.delete();
    log_last.delete();
    hold_data.delete();
    cyc = 0;
  endtask

  task automatic compare_and_advance();
    bit ev;
    bit found;
    int o;
    int p;
    o  = m_owner;
    ev = 1'b0;
    if (o >= 0) ev = port_en[o] && (q[o].size() > 0);
    chk("valid", int'(out_valid), int'(ev));
    chk("r_en", int'(fifo_r_en), (ev && out_ready) ? (1 << o) : 0);
    chk("last", int'(out_last), int'(ev && (m_taken == MB - 1)));
    chk("busy", int'(busy), int'(o >= 0));
    if (o >= 0) chk("src", int'(out_src), o);
    if (ev) chk("data", int'(out_data), int'(q[o][0]));
    if (fifo_r_en != '0) begin
      log_src.push_back(int'(out_src));
      log_cyc.push_back(cyc);
      log_data.push_back(int'(out_data));
    end
    if (out_last) log_last.push_back(cyc);
    if (out_valid && !out_ready) hold_data.push_back(int'(out_data));
    if (!rst) model_reset();
    else if (o < 0) begin
      found = 1'b0;
      for (int k = 1; k <= N; k++) begin
        p = (m_prev + k) % N;
        if (!found && port_en[p] && q[p].size() > 0) begin
          found   = 1'b1;
          m_owner = p;
          m_taken = 0;
        end
      end
    end else if (!ev) begin
      m_prev  = o;
      m_owner = -1;
    end else if (out_ready) begin
      m_taken++;
      if (m_taken == MB) begin
        m_prev  = o;
        m_owner = -1;
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    compare_and_advance();
    pend = fifo_r_en;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++)
      if (pend[i] && q[i].size() > 0) void'(q[i].pop_front());
    cyc++;
    drive();
  endtask

  function automatic bit pending(logic [N-1:0] mask);
    bit r;
    r = (m_owner >= 0);
    for (int i = 0; i < N; i++) if (mask[i] && q[i].size() > 0) r = 1'b1;
    return r;
  endfunction

  task automatic run_until(logic [N-1:0] mask, int max_steps, string name);
    int n;
    n = 0;
    while (pending(mask) && n < max_steps) begin
      step();
      n++;
    end
    if (pending(mask)) begin
      total++;
      bad++;
      $display("FAIL %s drain did not finish within %0d cycles", name, max_steps);
    end
  endtask

  // Called just after a rising edge; checks outputs clear while rst is still low.
  task automatic do_reset(string tag);
    #2 rst = 1'b0;
    #1;
    chk({tag, "_rst_r_en"}, int'(fifo_r_en), 0);
    chk({tag, "_rst_valid"}, int'(out_valid), 0);
    chk({tag, "_rst_last"}, int'(out_last), 0);
    chk({tag, "_rst_busy"}, int'(busy), 0);
    chk({tag, "_rst_src"}, int'(out_src), 0);
    chk({tag, "_rst_data"}, int'(out_data), 0);
    model_reset();
    step();
    rst = 1'b1;
  endtask

  initial begin
    int e[$];
    int n0;
    port_en   = '1;
    out_ready = 1'b1;
    model_reset();
    drive();
    @(posedge clk);
    #1;

    // 1: idle after reset, then FIFO2 with 6 words
    do_reset("t1");
    for (int k = 0; k < 3; k++) step();
    clear_logs();
    load(2, 6);
    run_until('1, 40, "t1");
    e = '{1, 2, 3, 4, 6, 7};
    chk_list("t1_pop_cyc", log_cyc, e);
    e = '{4};
    chk_list("t1_last_cyc", log_last, e);
    e = '{2, 2, 2, 2, 2, 2};
    chk_list("t1_src", log_src, e);

    // 2: all four FIFOs loaded, strict rotation 0,1,2,3
    do_reset("t2");
    clear_logs();
    for (int i = 0; i < N; i++) load(i, 8);
    run_until('1, 120, "t2");
    e.delete();
    for (int g = 0; g < 8; g++) for (int k = 0; k < 4; k++) e.push_back(g % 4);
    chk_list("t2_src", log_src, e);
    chk("t2_last_count", log_last.size(), 8);

    // 3: FIFO1 runs dry mid-grant, FIFO2 follows; no full burst anywhere
    do_reset("t3");
    clear_logs();
    load(1, 2);
    load(2, 3);
    run_until('1, 40, "t3");
    e = '{1, 1, 2, 2, 2};
    chk_list("t3_src", log_src, e);
    e = '{1, 2, 5, 6, 7};
    chk_list("t3_pop_cyc", log_cyc, e);
    chk("t3_last_count", log_last.size(), 0);

    // 4: out_ready stalls hold the word without popping
    do_reset("t4");
    clear_logs();
    load(3, 4);
    e = '{1, 1, 0, 0, 1, 1, 1, 1, 1, 1};
    for (int c = 0; c < 10; c++) begin
      out_ready = e[c][0];
      step();
    end
    out_ready = 1'b1;
    e = '{1, 4, 5, 6};
    chk_list("t4_pop_cyc", log_cyc, e);
    e = '{192, 193, 194, 195};
    chk_list("t4_data", log_data, e);
    e = '{193, 193};
    chk_list("t4_hold", hold_data, e);

    // 5: port 0 disabled mid-burst, skipped until re-enabled
    do_reset("t5");
    clear_logs();
    load(0, 8);
    load(1, 8);
    for (int c = 0; c < 3; c++) step();
    port_en = 4'b1110;
    run_until(4'b0010, 60, "t5a");
    port_en = 4'b1111;
    run_until('1, 60, "t5b");
    e = '{0, 0};
    for (int k = 0; k < 8; k++) e.push_back(1);
    for (int k = 0; k < 6; k++) e.push_back(0);
    chk_list("t5_src", log_src, e);
    chk("t5_third_pop_cyc", log_cyc[2], 5);

    // 6: async reset mid-burst; arbitration restarts from port 0
    do_reset("t6pre");
    clear_logs();
    load(1, 8);
    step();
    step();
    load(0, 4);
    load(3, 4);
    step();
    do_reset("t6");
    chk("t6_q1_left", q[1].size(), 6);
    n0 = log_src.size();
    run_until('1, 80, "t6");
    if (log_src.size() > n0) chk("t6_first_src", log_src[n0], 0);
    else chk("t6_pops_after_reset", log_src.size() - n0, 14);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
